// File: rtl/pe_inject_arb.sv
// Round-robin injection arbiter sharing one Hoplite switch injection port among N_REQ local sources.
// Define PE_ARB_LOOPBACK_EN to divert self-addressed packets to the lb_pkt/lb_vld port.
module pe_inject_arb #(
   parameter int P_W   = 16,
   parameter int X_AW  = 2,
   parameter int Y_AW  = 2,
   parameter int X_POS = 0,
   parameter int Y_POS = 0,
   parameter int N_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ*P_W-1:0]     req_pkt,
   input  logic [N_REQ-1:0]         req_vld,
   output logic [N_REQ-1:0]         req_rdy,
   input  logic                     sw_rdy,
   output logic [P_W-1:0]           out_pkt,
   output logic                     out_vld,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic [P_W-1:0]           lb_pkt,
   output logic                     lb_vld
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [ID_W:0]   N_REQ_L = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] rr_ptr, win_id, ptr_nxt;
   logic [ID_W:0]   idx;
   logic            win_vld, slot_free, take, load;
   logic [P_W-1:0]  win_pkt;

   assign slot_free = (state == EMPTY) | sw_rdy;
   assign out_vld   = (state == FULL);

   // Rotating priority search starting at rr_ptr
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= N_REQ_L) idx = idx - N_REQ_L;
         if (!win_vld && req_vld[idx[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = idx[ID_W-1:0];
         end
      end
   end

   assign win_pkt = req_pkt[win_id*P_W +: P_W];
   assign take    = slot_free & win_vld & ~rst;
   assign ptr_nxt = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

   always_comb begin
      req_rdy = '0;
      if (take) req_rdy[win_id] = 1'b1;
   end

`ifdef PE_ARB_LOOPBACK_EN
   localparam logic [X_AW+Y_AW-1:0] SELF_ADDR = {X_POS[X_AW-1:0], Y_POS[Y_AW-1:0]};
   logic is_self, lb_take;

   assign is_self = (win_pkt[P_W-1 -: X_AW+Y_AW] == SELF_ADDR);
   assign lb_take = take & is_self;
   assign load    = take & ~is_self;

   always_ff @(posedge clk) begin
      if (rst) begin
         lb_vld <= 1'b0;
         lb_pkt <= '0;
      end else begin
         lb_vld <= lb_take;
         if (lb_take) lb_pkt <= win_pkt;
      end
   end
`else
   assign load   = take;
   assign lb_vld = 1'b0;
   assign lb_pkt = '0;
`endif

   // Output slot: FULL holds until the switch accepts
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (load) state_nxt = FULL;
         FULL:  if (sw_rdy) state_nxt = load ? FULL : EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         rr_ptr   <= '0;
         out_pkt  <= '0;
         grant_id <= '0;
      end else begin
         state <= state_nxt;
         if (take) rr_ptr <= ptr_nxt;
         if (load) begin
            out_pkt  <= win_pkt;
            grant_id <= win_id;
         end
      end
   end

endmodule

// File: tb/tb_pe_inject_arb.sv
// Scoreboard bench for pe_inject_arb (N_REQ=4, P_W=16, PE at x=1, y=2).
module tb_pe_inject_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] req_pkt = '0;
   logic [3:0]  req_vld = '0;
   logic [3:0]  req_rdy;
   logic        sw_rdy = 1'b0;
   logic [15:0] out_pkt;
   logic        out_vld;
   logic [1:0]  grant_id;
   logic [15:0] lb_pkt;
   logic        lb_vld;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] exp_q[$];
   logic [15:0] lb_q[$];
   logic [15:0] src_pkt [4];

   logic       m_full = 1'b0;
   logic       m_lb   = 1'b0;
   logic [1:0] m_ptr  = 2'd0;

   pe_inject_arb #(.P_W(16), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2), .N_REQ(4)) dut (
      .clk(clk), .rst(rst), .req_pkt(req_pkt), .req_vld(req_vld), .req_rdy(req_rdy),
      .sw_rdy(sw_rdy), .out_pkt(out_pkt), .out_vld(out_vld), .grant_id(grant_id),
      .lb_pkt(lb_pkt), .lb_vld(lb_vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_lb(input logic [15:0] p);
`ifdef PE_ARB_LOOPBACK_EN
      return p[15:12] == 4'b0110;
`else
      return 1'b0;
`endif
   endfunction

   // One cycle: drive at negedge, check outputs and grant, advance the reference model
   task automatic step(input logic [3:0] v, input logic sr, input logic r);
      logic [17:0] e;
      logic [15:0] le;
      logic [3:0]  exp_rdy;
      logic        found, take;
      logic [1:0]  w, c;
      @(negedge clk);
      rst = r;
      req_vld = v;
      sw_rdy = sr;
      for (int i = 0; i < 4; i++) req_pkt[i*16 +: 16] = src_pkt[i];
      #1;
      chk("out_vld", {31'd0, out_vld}, {31'd0, m_full});
      if (out_vld && sw_rdy) begin
         if (exp_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("out_pkt", {16'd0, out_pkt}, {16'd0, e[15:0]});
            chk("grant_id", {30'd0, grant_id}, {30'd0, e[17:16]});
         end
      end
      chk("lb_vld", {31'd0, lb_vld}, {31'd0, m_lb});
      if (lb_vld) begin
         if (lb_q.size() == 0) chk("lb_unexpected", 32'd1, 32'd0);
         else begin
            le = lb_q.pop_front();
            chk("lb_pkt", {16'd0, lb_pkt}, {16'd0, le});
         end
      end
`ifndef PE_ARB_LOOPBACK_EN
      chk("lb_pkt_zero", {16'd0, lb_pkt}, 32'd0);
`endif
      found = 1'b0;
      w = 2'd0;
      for (int k = 0; k < 4; k++) begin
         c = m_ptr + 2'(k);
         if (!found && v[c]) begin
            found = 1'b1;
            w = c;
         end
      end
      take = (!m_full || sr) && found && !r;
      exp_rdy = take ? (4'b0001 << w) : 4'b0000;
      chk("req_rdy", {28'd0, req_rdy}, {28'd0, exp_rdy});
      if (r) begin
         m_full = 1'b0;
         m_lb = 1'b0;
         m_ptr = 2'd0;
         exp_q.delete();
         lb_q.delete();
      end else begin
         m_lb = 1'b0;
         if (take) begin
            m_ptr = w + 2'd1;
            if (is_lb(src_pkt[w])) begin
               lb_q.push_back(src_pkt[w]);
               m_lb = 1'b1;
               m_full = m_full && !sr;
            end else begin
               exp_q.push_back({w, src_pkt[w]});
               m_full = 1'b1;
            end
            src_pkt[w] = 16'($urandom);
         end else begin
            m_full = m_full && !sr;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) src_pkt[i] = 16'h1100 + 16'(i);
      repeat (2) @(posedge clk);
      step(4'b0000, 1'b0, 1'b1);
      chk("rst_out_pkt", {16'd0, out_pkt}, 32'd0);
      chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
      chk("rst_lb_pkt", {16'd0, lb_pkt}, 32'd0);

      // Single source
      src_pkt[0] = 16'h5A01;
      step(4'b0001, 1'b1, 1'b0);
      chk("t1_rdy", {28'd0, req_rdy}, 32'h1);
      step(4'b0000, 1'b1, 1'b0);
      chk("t1_out", {16'd0, out_pkt}, 32'h5A01);
      chk("t1_gid", {30'd0, grant_id}, 32'd0);

      // All request: order 0,1,2,3,0,1 (pointer is 1 after test 1, so realign with reset)
      step(4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         step(4'b1111, 1'b1, 1'b0);
         chk("t2_order", {28'd0, req_rdy}, {28'd0, 4'b0001 << (k % 4)});
      end

      // Fairness between 0 and 3: pointer is 2 now, so 3 first
      for (int k = 0; k < 4; k++) begin
         step(4'b1001, 1'b1, 1'b0);
         chk("t4_alt", {28'd0, req_rdy}, (k % 2 == 0) ? 32'h8 : 32'h1);
      end

      // Backpressure hold
      step(4'b0000, 1'b1, 1'b0);
      src_pkt[1] = 16'h1234;
      step(4'b0010, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(4'b0010, 1'b0, 1'b0);
         chk("t3_hold_pkt", {16'd0, out_pkt}, 32'h1234);
         chk("t3_hold_rdy", {28'd0, req_rdy}, 32'h0);
      end
      step(4'b0010, 1'b1, 1'b0);
      chk("t3_reload", {28'd0, req_rdy}, 32'h2);

      // Reset while FULL and stalled; pointer was 2, reset must return it to 0
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0110, 1'b1, 1'b0);
      chk("t5_out_vld", {31'd0, out_vld}, 32'd0);
      chk("t5_out_pkt", {16'd0, out_pkt}, 32'd0);
      chk("t5_first", {28'd0, req_rdy}, 32'h2);
      step(4'b0000, 1'b1, 1'b0);

      // Self-addressed packet
      src_pkt[0] = 16'h6ABC;
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
`ifdef PE_ARB_LOOPBACK_EN
      chk("t6_lb_vld", {31'd0, lb_vld}, 32'd1);
      chk("t6_out_vld", {31'd0, out_vld}, 32'd0);
`else
      chk("t6_out_pkt", {16'd0, out_pkt}, 32'h6ABC);
`endif
      step(4'b0000, 1'b1, 1'b0);

      // Random traffic and backpressure
      for (int k = 0; k < 60; k++)
         step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);

      repeat (3) step(4'b0000, 1'b1, 1'b0);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk("lb_q_empty", lb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
